// File: rtl/mem_stage_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_types (package)
//  Brief    : Shared funct3 encodings, LSU state type and the access legality
//             check used by the MEM-stage load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_types;

  // Access size / sign encodings carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // True when an access must be faulted instead of reaching the bus:
  // simultaneous read+write, an unsupported funct3, or a misaligned address.
  function automatic logic lsu_illegal(input logic       rd,
                                       input logic       wr,
                                       input logic [2:0] f3,
                                       input logic [1:0] a);
    logic bad_f3;
    logic misal;
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (f3)
      F3_B:    ;
      F3_H:    misal  = a[0];
      F3_W:    misal  = |a;
      F3_BU:   bad_f3 = wr;
      F3_HU: begin
        bad_f3 = wr;
        misal  = a[0];
      end
      default: bad_f3 = 1'b1;
    endcase
    return (rd & wr) | bad_f3 | misal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Brief    : Selects the addressed byte/halfword lane of a read word and
//             sign- or zero-extends it according to funct3.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_load_align
  import cpu_types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_w;
  logic [15:0] half_w;

  // Lane selection followed by extension; unsupported encodings return zero
  always_comb begin
    byte_w = rdata_i[7:0];
    case (addr_lo_i)
      2'd0: byte_w = rdata_i[7:0];
      2'd1: byte_w = rdata_i[15:8];
      2'd2: byte_w = rdata_i[23:16];
      2'd3: byte_w = rdata_i[31:24];
      default: byte_w = rdata_i[7:0];
    endcase
    half_w = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (funct3_i)
      F3_B:    result_o = {{24{byte_w[7]}}, byte_w};
      F3_BU:   result_o = {24'h0, byte_w};
      F3_H:    result_o = {{16{half_w[15]}}, half_w};
      F3_HU:   result_o = {16'h0, half_w};
      F3_W:    result_o = rdata_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Brief    : MEM-stage load/store unit. Drives a req/gnt/rvalid data bus,
//             stalls the pipeline while an access is in flight, faults
//             misaligned/illegal accesses without bus activity and returns
//             aligned, extended load data.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
  parameter int BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_fault
);

  import cpu_types::*;

  lsu_state_t  state_q;
  logic [31:0] rdata_q;
  logic        fault_q;

  logic        access_w;
  logic        illegal_w;
  logic        legal_w;
  logic        timeout_w;
  logic [31:0] align_w;

  assign access_w  = mem_read | mem_write;
  assign illegal_w = access_w & lsu_illegal(mem_read, mem_write, funct3, addr[1:0]);
  assign legal_w   = access_w & ~illegal_w;

  // Inputs are frozen by stall for the whole access, so the request fields
  // can be derived directly from them in every state.
  assign dbus_we   = mem_write;
  assign dbus_addr = {addr[31:2], 2'b00};

  lsu_load_align u_align (
    .rdata_i   (dbus_rdata),
    .addr_lo_i (addr[1:0]),
    .funct3_i  (funct3),
    .result_o  (align_w)
  );

  // Store byte-enables and lane replication; loads always read the full word
  always_comb begin
    dbus_be    = 4'b1111;
    dbus_wdata = wdata;
    if (mem_write) begin
      case (funct3)
        F3_B: begin
          dbus_be    = 4'b0001 << addr[1:0];
          dbus_wdata = {4{wdata[7:0]}};
        end
        F3_H: begin
          dbus_be    = 4'b0011 << addr[1:0];
          dbus_wdata = {2{wdata[15:0]}};
        end
        default: begin
          dbus_be    = 4'b1111;
          dbus_wdata = wdata;
        end
      endcase
    end
  end

  // Bus-wait watchdog: counts cycles spent in REQ/RESP, saturating at the
  // limit so a grant on the last allowed cycle still times out cleanly in RESP.
  generate
    if (BUS_TIMEOUT > 0) begin : g_timeout
      localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BUS_TIMEOUT - 1);
      logic [CNT_W-1:0] cnt_q;
      logic             busy_w;

      assign busy_w    = (state_q == REQ) || (state_q == RESP);
      assign timeout_w = busy_w && (cnt_q == CNT_MAX);

      // Advance while waiting on the bus, clear whenever not waiting
      always_ff @(posedge clk) begin
        if (reset || !busy_w) begin
          cnt_q <= '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign timeout_w = 1'b0;
    end
  endgenerate

  // Access sequencing and capture of the result presented in DONE.
  // A bus completion in the same cycle as the timeout takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rdata_q <= 32'h0;
          fault_q <= 1'b0;
          if (legal_w) begin
            if (dbus_gnt) state_q <= mem_read ? RESP : DONE;
            else          state_q <= REQ;
          end
        end
        REQ: begin
          if (dbus_gnt) begin
            state_q <= mem_read ? RESP : DONE;
          end else if (timeout_w) begin
            state_q <= DONE;
            fault_q <= 1'b1;
            rdata_q <= 32'h0;
          end
        end
        RESP: begin
          if (dbus_rvalid) begin
            state_q <= DONE;
            rdata_q <= align_w;
          end else if (timeout_w) begin
            state_q <= DONE;
            fault_q <= 1'b1;
            rdata_q <= 32'h0;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake and pipeline-facing outputs; reset drops them at once
  always_comb begin
    dbus_req  = 1'b0;
    stall     = 1'b0;
    mem_fault = 1'b0;
    mem_rdata = 32'h0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          dbus_req  = legal_w;
          stall     = legal_w;
          mem_fault = illegal_w;
        end
        REQ: begin
          dbus_req = 1'b1;
          stall    = 1'b1;
        end
        RESP: begin
          stall = 1'b1;
        end
        DONE: begin
          mem_fault = fault_q;
          mem_rdata = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Brief    : Directed self-checking bench for mem_stage_lsu (BUS_TIMEOUT=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        mem_fault;

  int errors = 0;
  int checks = 0;

  mem_stage_lsu #(.BUS_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .dbus_req    (dbus_req),
    .dbus_we     (dbus_we),
    .dbus_addr   (dbus_addr),
    .dbus_be     (dbus_be),
    .dbus_wdata  (dbus_wdata),
    .dbus_gnt    (dbus_gnt),
    .dbus_rvalid (dbus_rvalid),
    .dbus_rdata  (dbus_rdata),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .mem_fault   (mem_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'b000;
    addr        = 32'h0;
    wdata       = 32'h0;
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'b0;
    dbus_rdata  = 32'h0;
  endtask

  // Pipeline-facing outputs in one call: req, stall, fault, rdata
  task automatic chk_out(input string tag, input logic req, input logic stl,
                         input logic flt, input logic [31:0] rd);
    chk({tag, ".req"},   {31'h0, dbus_req},  {31'h0, req});
    chk({tag, ".stall"}, {31'h0, stall},     {31'h0, stl});
    chk({tag, ".fault"}, {31'h0, mem_fault}, {31'h0, flt});
    chk({tag, ".rdata"}, mem_rdata, rd);
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    tick();
    tick();
    chk_out("rst_hold", 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    chk_out("idle", 1'b0, 1'b0, 1'b0, 32'h0);

    // ---- SW 0x100, grant in the first cycle
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h100; wdata = 32'hDEADBEEF;
    dbus_gnt  = 1'b1;
    #1;
    chk_out("sw_idle", 1'b1, 1'b1, 1'b0, 32'h0);
    chk("sw.we",    {31'h0, dbus_we}, 32'h1);
    chk("sw.addr",  dbus_addr, 32'h100);
    chk("sw.be",    {28'h0, dbus_be}, 32'hF);
    chk("sw.wdata", dbus_wdata, 32'hDEADBEEF);
    tick();
    dbus_gnt = 1'b0;
    #1;
    chk_out("sw_done", 1'b0, 1'b0, 1'b0, 32'h0);
    idle_in();
    tick();
    chk_out("sw_after", 1'b0, 1'b0, 1'b0, 32'h0);

    // ---- LB 0x203, grant on the third request cycle; rvalid in grant cycle ignored
    mem_read = 1'b1; funct3 = 3'b000; addr = 32'h203;
    #1;
    chk_out("lb_c1", 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lb.we",   {31'h0, dbus_we}, 32'h0);
    chk("lb.addr", dbus_addr, 32'h200);
    chk("lb.be",   {28'h0, dbus_be}, 32'hF);
    tick();
    chk_out("lb_c2", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    dbus_gnt = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h0000_0000;
    #1;
    chk_out("lb_c3", 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    #1;
    chk_out("lb_resp", 1'b0, 1'b1, 1'b0, 32'h0);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h80FF_1234;
    tick();
    dbus_rvalid = 1'b0;
    #1;
    chk_out("lb_done", 1'b0, 1'b0, 1'b0, 32'hFFFF_FF80);
    idle_in();
    tick();

    // ---- LBU 0x203, immediate grant
    mem_read = 1'b1; funct3 = 3'b100; addr = 32'h203; dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h80FF_1234;
    #1;
    chk_out("lbu_resp", 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    dbus_rvalid = 1'b0;
    #1;
    chk_out("lbu_done", 1'b0, 1'b0, 1'b0, 32'h0000_0080);
    idle_in();
    tick();

    // ---- SH 0x302
    mem_write = 1'b1; funct3 = 3'b001; addr = 32'h302; wdata = 32'h0000_ABCD;
    dbus_gnt  = 1'b1;
    #1;
    chk("sh.be",    {28'h0, dbus_be}, 32'hC);
    chk("sh.wdata", dbus_wdata, 32'hABCD_ABCD);
    chk("sh.addr",  dbus_addr, 32'h300);
    tick();
    dbus_gnt = 1'b0;
    #1;
    chk_out("sh_done", 1'b0, 1'b0, 1'b0, 32'h0);
    idle_in();
    tick();

    // ---- SB 0x101 lane 1
    mem_write = 1'b1; funct3 = 3'b000; addr = 32'h101; wdata = 32'h1234_5678;
    #1;
    chk("sb.be",    {28'h0, dbus_be}, 32'h2);
    chk("sb.wdata", dbus_wdata, 32'h7878_7878);
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    idle_in();
    tick();

    // ---- LHU 0x302
    mem_read = 1'b1; funct3 = 3'b101; addr = 32'h302; dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'hABCD_0000;
    tick();
    dbus_rvalid = 1'b0;
    #1;
    chk_out("lhu_done", 1'b0, 1'b0, 1'b0, 32'h0000_ABCD);
    idle_in();
    tick();

    // ---- LH 0x300 sign-extended from the low half
    mem_read = 1'b1; funct3 = 3'b001; addr = 32'h300; dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_9ABC;
    tick();
    dbus_rvalid = 1'b0;
    #1;
    chk_out("lh_done", 1'b0, 1'b0, 1'b0, 32'hFFFF_9ABC);
    idle_in();
    tick();

    // ---- Misaligned / illegal accesses: fault, no bus activity
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h101;
    #1;
    chk_out("lw_mis", 1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    chk_out("lw_mis_hold", 1'b0, 1'b0, 1'b1, 32'h0);
    funct3 = 3'b011; addr = 32'h100;
    #1;
    chk_out("ld_f3_011", 1'b0, 1'b0, 1'b1, 32'h0);
    mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b100; addr = 32'h100;
    #1;
    chk_out("st_f3_100", 1'b0, 1'b0, 1'b1, 32'h0);
    mem_read = 1'b1; funct3 = 3'b010;
    #1;
    chk_out("rd_and_wr", 1'b0, 1'b0, 1'b1, 32'h0);
    mem_read = 1'b0; funct3 = 3'b001; addr = 32'h103;
    #1;
    chk_out("sh_mis", 1'b0, 1'b0, 1'b1, 32'h0);
    idle_in();
    tick();
    chk_out("after_faults", 1'b0, 1'b0, 1'b0, 32'h0);

    // ---- Timeout: LW granted, rvalid never arrives
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400; dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #0;
      chk_out($sformatf("to_resp%0d", i), 1'b0, 1'b1, 1'b0, 32'h0);
      tick();
    end
    chk_out("to_done", 1'b0, 1'b0, 1'b1, 32'h0);
    idle_in();
    tick();
    dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFE_F00D;
    #1;
    chk_out("to_late_rv", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("to_late_rv2", 1'b0, 1'b0, 1'b0, 32'h0);
    dbus_rvalid = 1'b0;

    // ---- Reset during RESP, then a clean LW
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500; dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0;
    #1;
    chk_out("rr_resp", 1'b0, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    chk_out("rr_assert", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    dbus_rvalid = 1'b1; dbus_rdata = 32'h5555_5555;
    #1;
    chk_out("rr_held", 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0; dbus_rvalid = 1'b0;
    #1;
    chk_out("rr_reissue", 1'b1, 1'b1, 1'b0, 32'h0);
    dbus_gnt = 1'b1;
    tick();
    dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
    tick();
    dbus_rvalid = 1'b0;
    #1;
    chk_out("rr_lw_done", 1'b0, 1'b0, 1'b0, 32'h1234_5678);
    idle_in();
    tick();
    chk_out("end_idle", 1'b0, 1'b0, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
